// File: rtl/tts_pkg.sv
// tts_pkg: shared state encoding, default sizing and slice helper for truth_table_sequencer.
package tts_pkg;
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
    localparam int N_IN_DEF = 3;
    localparam int NVEC = 2**N_IN_DEF;
    function automatic int slice_lo(input int vec, input int width);
        return vec * width;
    endfunction
endpackage

// File: rtl/tts_dwell_counter.sv
// tts_dwell_counter: loadable down-counter that parks at zero and flags it.
module tts_dwell_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (i_en && r_cnt != '0) r_cnt <= r_cnt - W'(1);
    end
    assign o_zero = r_cnt == '0;
endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: walks every input vector, dwells, samples the datapath
// and scores the response against a truth table latched at start.
module truth_table_sequencer
    import tts_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = 2,
    parameter int DWELL = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [(2**N_IN)*N_OUT-1:0]   exp_table,
    output logic [N_IN-1:0]              dut_in,
    input  logic [N_OUT-1:0]             dut_out,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [N_IN:0]                fail_count,
    output logic                         first_fail_valid,
    output logic [N_IN-1:0]              first_fail_vec,
    output logic [(2**N_IN)*N_OUT-1:0]   captured
);
    localparam int NV = 2**N_IN;
    localparam int DW = $clog2(DWELL + 1);

    state_t            r_state, w_next;
    logic [N_IN-1:0]   r_vec, r_ffvec;
    logic [N_IN:0]     r_fail;
    logic              r_ffv, r_pass;
    logic [N_OUT-1:0]  r_exp [NV];
    logic [N_OUT-1:0]  r_cap [NV];
    logic [N_OUT-1:0]  w_tab [NV];
    logic              w_accept, w_sample, w_last, w_miss, w_zero;

    genvar g;
    for (g = 0; g < NV; g++) begin : g_slice
        assign w_tab[g] = exp_table[slice_lo(g, N_OUT) +: N_OUT];
        assign captured[slice_lo(g, N_OUT) +: N_OUT] = r_cap[g];
    end

    assign w_accept = r_state == IDLE && start;
    assign w_sample = r_state == SAMPLE;
    assign w_last   = r_vec == N_IN'(NV - 1);
    assign w_miss   = w_sample && dut_out != r_exp[r_vec];

    tts_dwell_counter #(.W(DW)) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_accept || (w_sample && !w_last)),
        .i_en   (r_state == APPLY),
        .i_val  (DW'(DWELL - 1)),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = r_state == IDLE   ? (start  ? APPLY : IDLE)  :
                 r_state == APPLY  ? (w_zero ? SAMPLE : APPLY) :
                 r_state == SAMPLE ? (w_last ? DONE : APPLY)   : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec   <= '0;
            r_fail  <= '0;
            r_ffv   <= 1'b0;
            r_ffvec <= '0;
            r_pass  <= 1'b0;
            r_exp   <= '{default: '0};
            r_cap   <= '{default: '0};
        end else if (w_accept) begin
            r_vec   <= '0;
            r_fail  <= '0;
            r_ffv   <= 1'b0;
            r_ffvec <= '0;
            r_pass  <= 1'b0;
            r_exp   <= w_tab;
            r_cap   <= '{default: '0};
        end else if (w_sample) begin
            r_cap[r_vec] <= dut_out;
            if (w_miss) r_fail <= r_fail + (N_IN+1)'(1);
            if (w_miss && !r_ffv) begin
                r_ffv   <= 1'b1;
                r_ffvec <= r_vec;
            end
            // pass is settled on the last sample so it is already valid while done pulses
            if (w_last) r_pass <= !w_miss && r_fail == '0;
            else r_vec <= r_vec + N_IN'(1);
        end
    end

    assign dut_in           = (r_state == APPLY || w_sample) ? r_vec : '0;
    assign busy             = r_state != IDLE;
    assign done             = r_state == DONE;
    assign pass             = r_pass;
    assign fail_count       = r_fail;
    assign first_fail_valid = r_ffv;
    assign first_fail_vec   = r_ffvec;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: full-adder datapath with injectable faults, scored against a table-level model.
module tb_truth_table_sequencer;
    import tts_pkg::*;
    localparam int NV = NVEC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] exp_tab = '0;
    logic [15:0] fmask = '0;
    logic        start_a [2];
    logic [2:0]  in_a    [2];
    logic [1:0]  out_a   [2];
    logic        busy_a  [2];
    logic        done_a  [2];
    logic        pass_a  [2];
    logic        ffv_a   [2];
    logic [3:0]  fc_a    [2];
    logic [2:0]  ffvec_a [2];
    logic [15:0] cap_a   [2];
    int n_chk = 0;
    int n_bad = 0;

    function automatic logic [1:0] fa(input logic [2:0] v);
        int s;
        s = int'(v[2]) + int'(v[1]) + int'(v[0]);
        return {1'(s % 2), 1'(s / 2)};
    endfunction

    genvar g;
    for (g = 0; g < 2; g++) begin : g_dp
        assign out_a[g] = fa(in_a[g]) ^ 2'(fmask >> (2 * in_a[g]));
    end

    truth_table_sequencer #(.N_IN(3), .N_OUT(2), .DWELL(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .exp_table(exp_tab),
        .dut_in(in_a[0]), .dut_out(out_a[0]), .busy(busy_a[0]), .done(done_a[0]),
        .pass(pass_a[0]), .fail_count(fc_a[0]), .first_fail_valid(ffv_a[0]),
        .first_fail_vec(ffvec_a[0]), .captured(cap_a[0])
    );

    truth_table_sequencer #(.N_IN(3), .N_OUT(2), .DWELL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .exp_table(exp_tab),
        .dut_in(in_a[1]), .dut_out(out_a[1]), .busy(busy_a[1]), .done(done_a[1]),
        .pass(pass_a[1]), .fail_count(fc_a[1]), .first_fail_valid(ffv_a[1]),
        .first_fail_vec(ffvec_a[1]), .captured(cap_a[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic run(input int id, input int d, input logic [15:0] tbl, input logic [15:0] m, input bit noise);
        int total, nf, first;
        logic [15:0] cap;
        logic [1:0] o;
        total = NV * (d + 1) + 1;
        cap = '0;
        nf = 0;
        first = -1;
        for (int v = 0; v < NV; v++) begin
            o = fa(3'(v)) ^ 2'(m >> (2 * v));
            cap = cap | (16'(o) << (2 * v));
            if (o != 2'(tbl >> (2 * v))) begin
                nf++;
                if (first < 0) first = v;
            end
        end
        @(negedge clk);
        chk("idle", 64'({busy_a[id], done_a[id]}), 64'(0));
        exp_tab = tbl;
        fmask = m;
        start_a[id] = 1'b1;
        @(posedge clk);
        #1 start_a[id] = 1'b0;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            chk("trace", 64'({busy_a[id], done_a[id], in_a[id]}),
                64'({1'b1, k == total, k < total ? 3'((k - 1) / (d + 1)) : 3'd0}));
            if (noise && k < total) begin
                start_a[id] = 1'($urandom);
                exp_tab = 16'($urandom);
            end else start_a[id] = 1'b0;
        end
        chk("pass", 64'(pass_a[id]), 64'(nf == 0));
        chk("fail_count", 64'(fc_a[id]), 64'(nf));
        chk("ff_valid", 64'(ffv_a[id]), 64'(nf > 0));
        chk("ff_vec", 64'(ffvec_a[id]), 64'(first < 0 ? 0 : first));
        chk("captured", 64'(cap_a[id]), 64'(cap));
    endtask

    initial begin
        logic [15:0] m, t;
        start_a[0] = 1'b0;
        start_a[1] = 1'b0;
        #12;
        for (int i = 0; i < 2; i++)
            chk("reset", 64'({busy_a[i], done_a[i], in_a[i], pass_a[i], fc_a[i], ffv_a[i], ffvec_a[i], cap_a[i]}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 4, 16'hD668, 16'h0, 1'b0);
        run(0, 4, 16'hD669, 16'h0, 1'b0);
        run(0, 4, 16'h0000, 16'h0, 1'b0);
        run(0, 4, 16'h2997, 16'h0, 1'b0);
        run(0, 4, 16'hD668, 16'h0, 1'b1);
        run(0, 4, 16'hD668, 16'h0, 1'b0);
        @(negedge clk);
        exp_tab = 16'hD668;
        fmask = '0;
        start_a[0] = 1'b1;
        @(posedge clk);
        #1 start_a[0] = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            chk("pre_rst", 64'(in_a[0]), 64'((k - 1) / 5));
        end
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 64'({busy_a[0], done_a[0], in_a[0], pass_a[0], fc_a[0], ffv_a[0], ffvec_a[0], cap_a[0]}), 64'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_hold", 64'(done_a[0]), 64'(0));
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst", 64'({busy_a[0], done_a[0]}), 64'(0));
        end
        run(0, 4, 16'hD668, 16'h0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            m = 16'($urandom) & 16'($urandom) & 16'($urandom);
            t = r[0] ? 16'($urandom) : 16'hD668;
            run(0, 4, t, m, 1'($urandom));
        end
        run(1, 1, 16'hD668, 16'h0, 1'b0);
        run(1, 1, 16'hD668, 16'h0300, 1'b1);
        run(1, 1, 16'($urandom), 16'($urandom), 1'b0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
Clocked controller that exhaustively exercises a small combinational datapath, such as the 3-input/2-output logic blocks in the digital design labs. On a start request it drives every input combination in ascending binary order and holds each vector for a settle interval. It captures the datapath outputs and compares them against a latched expected truth table. It reports done, pass/fail, a mismatch count and the first failing vector, which replaces hand-written delay-based stimulus with a self-checking, synthesizable sequencer.

Parameters:
N_IN, 3, datapath input width; vectors 0 .. 2**N_IN-1.
N_OUT, 2, datapath output width.
DWELL, 4, settle cycles per vector before sampling; legal range >= 1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  run request; accepted only in IDLE.
exp_table  input  (2**N_IN)*N_OUT  expected outputs; slice [v*N_OUT +: N_OUT] is the expected output for vector v. Latched on start acceptance.
dut_in  output  N_IN  vector driven to the datapath; MSB is the first operand (p), LSB is the last (r).
dut_out  input  N_OUT  datapath response; MSB is the first output (x).
busy  output  1  high from the cycle after start acceptance through the DONE cycle.
done  output  1  one-cycle pulse at the end of a run.
pass  output  1  high when fail_count==0; valid from done and held until the next start acceptance.
fail_count  output  N_IN+1  number of mismatching vectors.
first_fail_valid  output  1  high when at least one mismatch has occurred.
first_fail_vec  output  N_IN  lowest-numbered mismatching vector.
captured  output  (2**N_IN)*N_OUT  observed outputs, same slicing as exp_table.

Behaviour:
- Reset is asynchronous, active-low, and may arrive mid-run.
  - Reset state: IDLE.
  - dut_in, busy, done, pass, fail_count, first_fail_valid, first_fail_vec, captured, the latched table, and the vector and dwell counters all clear to 0.
  - A run interrupted by reset is abandoned and produces no done pulse.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - start=1 latches exp_table, sets vec=0 and dwell=DWELL-1.
  - Clears fail_count, first_fail_valid, first_fail_vec, captured and pass.
  - Next state APPLY.
- APPLY:
  - dut_in=vec.
  - If dwell==0, go to SAMPLE; otherwise decrement dwell.
  - Occupies exactly DWELL cycles per vector.
- SAMPLE:
  - dut_in still equals vec.
  - Writes dut_out into captured[vec*N_OUT +: N_OUT] and compares it against the latched slice.
  - On mismatch: fail_count+1. If first_fail_valid==0, also set first_fail_valid=1 and first_fail_vec=vec.
  - If vec==2**N_IN-1: go to DONE. Otherwise vec+1, dwell reload to DWELL-1, go to APPLY.
- DONE:
  - done=1 for one cycle; pass=(fail_count==0) registered the same cycle.
  - Next state IDLE; dut_in returns to 0 in IDLE.
- Latency: start accepted at edge E0; done is high in cycle E0 + (2**N_IN)*(DWELL+1) + 1. With defaults that is cycle 41.
- start while busy, including the DONE cycle, is ignored and not queued.
- exp_table changes after acceptance have no effect on the run.
- vec must not wrap: the terminal vector exits to DONE. fail_count width N_IN+1 holds the all-fail value 2**N_IN.

Decomposition:
- Shared package tts_pkg holds:
  - the state enum (IDLE, APPLY, SAMPLE, DONE);
  - the localparam NVEC = 2**N_IN;
  - a slice-index helper function.
- One natural sub-module, tts_dwell_counter: loadable down-counter with load, enable and zero flag. FSM, compare and capture logic remain in the top.

Test Plan:
1. Full-adder reference DUT (first output = XOR, second = majority), exp_table=16'hD668, DWELL=4, pulse start → done at cycle 41, pass=1, fail_count=0, captured=16'hD668, dut_in visits 0..7 in order, each held 5 cycles.
2. Same DUT, exp_table=16'hD669 (vector 0 expects 01) → pass=0, fail_count=1, first_fail_valid=1, first_fail_vec=0.
3. exp_table=16'h0000 against full adder → fail_count=7 (vectors 1–7), first_fail_vec=1; all-inverted table 16'h2997 → fail_count=8, pass=0.
4. Assert start repeatedly during a run, and change exp_table mid-run → exactly one done pulse, results unchanged from scenario 1; a start in the cycle after done begins a new run.
5. Drop rst_n asynchronously while vec=5 in APPLY → all outputs 0 immediately, no done. After release, a new start gives a full correct run.
6. DWELL=1 build → each vector held 2 cycles, done at cycle 17, pass=1.
